uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter among N_REQ byte producers with round-robin fairness.

---
 rtl/uart_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 135 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART TX arbiter slice.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } arb_state_t;

  localparam int unsigned DATA_W_DEFAULT = 8;

  // Width needed to index n items, never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  winner,
  output logic             any_valid
);

  logic [ID_W-1:0] idx;

  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = ID_W'((32'(ptr) + k) % N_REQ);
      if (!any_valid && req[idx]) begin
        winner    = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among N_REQ byte producers.
// Optional start timeout enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned DATA_W      = DATA_W_DEFAULT,
  parameter int unsigned TIMEOUT_CYC = 16,
  localparam int unsigned ID_W       = idx_width(N_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_parity_en,
  output logic [N_REQ-1:0]          ack,
  output logic [ID_W-1:0]           grant_id,
  output logic                      tx_valid,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_parity_en,
  input  logic                      tx_busy,
  output logic                      arb_busy,
  output logic                      timeout_err
);

  if (N_REQ < 1 || TIMEOUT_CYC < 1) begin : g_cfg_check
    $error("uart_tx_arbiter: N_REQ and TIMEOUT_CYC must be at least 1");
  end

  arb_state_t        state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   win_id;
  logic              win_valid;
  logic [DATA_W-1:0] sel_data;
  logic              sel_par;
  logic [N_REQ-1:0]  sel_ack;
  logic [ID_W-1:0]   ptr_inc;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .req       (req),
    .ptr       (ptr),
    .winner    (win_id),
    .any_valid (win_valid)
  );

  always_comb begin
    sel_data = '0;
    sel_par  = 1'b0;
    sel_ack  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_id == ID_W'(i)) begin
        sel_data   = req_data[i*DATA_W +: DATA_W];
        sel_par    = req_parity_en[i];
        sel_ack[i] = 1'b1;
      end
    end
  end

  assign ptr_inc = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = idx_width(TIMEOUT_CYC);
  logic [CNT_W-1:0] cnt;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ptr          <= '0;
      grant_id     <= '0;
      ack          <= '0;
      tx_valid     <= 1'b0;
      tx_data      <= '0;
      tx_parity_en <= 1'b0;
      arb_busy     <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt          <= '0;
      timeout_err  <= 1'b0;
`endif
    end else begin
      ack      <= '0;
      tx_valid <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (win_valid && !tx_busy) begin
            state        <= ISSUE;
            grant_id     <= win_id;
            tx_data      <= sel_data;
            tx_parity_en <= sel_par;
            ack          <= sel_ack;
            tx_valid     <= 1'b1;
            arb_busy     <= 1'b1;
          end
        end
        ISSUE: begin
          state <= WAIT_START;
`ifdef UART_ARB_TIMEOUT_EN
          cnt   <= '0;
`endif
        end
        WAIT_START: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
          end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
            ptr         <= ptr_inc;
            arb_busy    <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
`endif
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            state    <= IDLE;
            ptr      <= ptr_inc;
            arb_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table plus hand-written corner sequences.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_parity_en;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_parity_en;
  logic        tx_busy;
  logic        arb_busy;
  logic        timeout_err;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ       (4),
    .DATA_W      (8),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_data      (req_data),
    .req_parity_en (req_parity_en),
    .ack           (ack),
    .grant_id      (grant_id),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_parity_en  (tx_parity_en),
    .tx_busy       (tx_busy),
    .arb_busy      (arb_busy),
    .timeout_err   (timeout_err)
  );

  typedef struct {
    logic [3:0] req;
    logic [1:0] g;
    logic [7:0] d;
    logic       p;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for the issue pulse, checks it, then plays a 10-cycle TX frame.
  task automatic do_frame(input logic [1:0] g, input logic [7:0] d, input logic p,
                          input string name, output int waited);
    logic [3:0] exp_ack;
    exp_ack = 4'b0001 << g;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!tx_valid && waited < 40);
    chk({name, " tx_valid"}, 32'(tx_valid), 32'd1);
    chk({name, " grant_id"}, 32'(grant_id), 32'(g));
    chk({name, " tx_data"}, 32'(tx_data), 32'(d));
    chk({name, " tx_parity_en"}, 32'(tx_parity_en), 32'(p));
    chk({name, " ack"}, 32'(ack), 32'(exp_ack));
    chk({name, " arb_busy issue"}, 32'(arb_busy), 32'd1);
    chk({name, " timeout_err"}, 32'(timeout_err), 32'd0);
    tick();
    chk({name, " pulse width"}, 32'({ack, tx_valid}), 32'd0);
    tx_busy = 1'b1;
    repeat (10) tick();
    chk({name, " arb_busy frame"}, 32'(arb_busy), 32'd1);
    tx_busy = 1'b0;
    tick();
    chk({name, " arb_busy idle"}, 32'(arb_busy), 32'd0);
  endtask

  initial begin
    int w;
    int n;

    tbl[0]  = '{4'b1111, 2'd0, 8'h11, 1'b1};
    tbl[1]  = '{4'b1111, 2'd1, 8'h22, 1'b0};
    tbl[2]  = '{4'b1111, 2'd2, 8'hA5, 1'b1};
    tbl[3]  = '{4'b1111, 2'd3, 8'h44, 1'b0};
    tbl[4]  = '{4'b1111, 2'd0, 8'h11, 1'b1};
    tbl[5]  = '{4'b0100, 2'd2, 8'hA5, 1'b1};
    tbl[6]  = '{4'b1000, 2'd3, 8'h44, 1'b0};
    tbl[7]  = '{4'b1001, 2'd0, 8'h11, 1'b1};
    tbl[8]  = '{4'b1001, 2'd3, 8'h44, 1'b0};
    tbl[9]  = '{4'b0010, 2'd1, 8'h22, 1'b0};
    tbl[10] = '{4'b0011, 2'd0, 8'h11, 1'b1};

    reset         = 1'b1;
    req           = '0;
    req_data      = 32'h44A5_2211;
    req_parity_en = 4'b0101;
    tx_busy       = 1'b0;
    repeat (3) tick();
    chk("reset outputs",
        32'({ack, grant_id, tx_valid, tx_data, tx_parity_en, arb_busy, timeout_err}), 32'd0);
    reset = 1'b0;
    tick();
    chk("idle no issue", 32'({ack, tx_valid, arb_busy}), 32'd0);

    for (int i = 0; i < 11; i++) begin
      req = tbl[i].req;
      do_frame(tbl[i].g, tbl[i].d, tbl[i].p, $sformatf("vec%0d", i), w);
      chk($sformatf("vec%0d latency", i), 32'(w), 32'd1);
    end

    // Pointer is 1. Foreign frame blocks the grant.
    tx_busy = 1'b1;
    req     = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("busy block %0d", i), 32'({tx_valid, arb_busy}), 32'd0);
    end
    tx_busy = 1'b0;
    do_frame(2'd0, 8'h11, 1'b1, "busy release", w);
    chk("busy release latency", 32'(w), 32'd1);

    // Pointer is 1: requester 2 wins, then reset lands in WAIT_DONE.
    req = 4'b0100;
    tick();
    chk("pre-reset grant", 32'({tx_valid, grant_id}), 32'({1'b1, 2'd2}));
    tick();
    tx_busy = 1'b1;
    tick();
    chk("pre-reset arb_busy", 32'(arb_busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid-frame reset outputs",
        32'({ack, grant_id, tx_valid, tx_data, tx_parity_en, arb_busy, timeout_err}), 32'd0);
    reset   = 1'b0;
    tx_busy = 1'b0;
    req     = 4'b1111;
    do_frame(2'd0, 8'h11, 1'b1, "after reset", w);
    chk("after reset latency", 32'(w), 32'd1);

    // Pointer is 1: requester 1 wins and the TX never starts.
    req = 4'b0110;
    tick();
    chk("stuck grant", 32'({tx_valid, grant_id}), 32'({1'b1, 2'd1}));
    tick();
`ifdef UART_ARB_TIMEOUT_EN
    n = 0;
    while (!timeout_err && n < 40) begin
      tick();
      n++;
    end
    chk("timeout delay", 32'(n), 32'd16);
    chk("timeout idle", 32'({tx_valid, arb_busy}), 32'd0);
    tick();
    chk("timeout pulse width", 32'(timeout_err), 32'd0);
    chk("post-timeout grant", 32'({tx_valid, grant_id, tx_data}), 32'({1'b1, 2'd2, 8'hA5}));
    tick();
    tx_busy = 1'b1;
    repeat (10) tick();
    tx_busy = 1'b0;
    tick();
    chk("post-timeout idle", 32'(arb_busy), 32'd0);
`else
    n = 0;
    repeat (30) begin
      tick();
      if (timeout_err !== 1'b0 || arb_busy !== 1'b1 || tx_valid !== 1'b0) n++;
    end
    chk("stuck wait holds", 32'(n), 32'd0);
    tx_busy = 1'b1;
    repeat (10) tick();
    tx_busy = 1'b0;
    tick();
    chk("stuck recover idle", 32'(arb_busy), 32'd0);
    req = 4'b0110;
    do_frame(2'd2, 8'hA5, 1'b1, "after stuck", w);
    chk("after stuck latency", 32'(w), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
